// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_e;

  // Only MULTU and DIVU launch an operation; everything else is a no-op.
  function automatic logic op_launches(input logic [1:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request / HI-LO result bundle between the pipeline and the mul/div unit.
interface muldiv_unit_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, dataA, dataB, wr_hi, wr_lo, wdata,
    input  hi_out, lo_out, busy, done
  );

  modport slave (
    input  start, op, dataA, dataB, wr_hi, wr_lo, wdata,
    output hi_out, lo_out, busy, done
  );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // With a zero divisor the subtraction always "fits", so the quotient fills
  // with ones and the remainder register simply shifts the dividend in.
  always_comb begin
    trial   = {rem_in, dividend_bit};
    diff    = trial - {1'b0, divisor};
    q_bit   = (trial >= {1'b0, divisor});
    rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MULTU/DIVU with HI/LO ownership; one result bit per cycle, busy stalls the pipe.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     div_rem;
  logic                 div_q;
  logic                 last_iter;

  // acc holds {partial remainder, dividend/quotient shifter} during DIV.
  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in       (acc_q[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc_q[WIDTH-1]),
    .divisor      (opnd_q),
    .rem_out      (div_rem),
    .q_bit        (div_q)
  );

  // acc holds {partial product, remaining multiplier bits} during MUL.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_q};
    last_iter = (cnt_q == CNT_W'(1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && op_launches(bus.op)) begin
          // A launching start swallows any mthi/mtlo issued in the same cycle.
          state_d = (bus.op == OP_MULTU) ? S_MUL : S_DIV;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          opnd_d  = (bus.op == OP_MULTU) ? bus.dataA : bus.dataB;
          acc_d   = {{WIDTH{1'b0}}, ((bus.op == OP_MULTU) ? bus.dataB : bus.dataA)};
        end else begin
          if (bus.wr_hi) hi_d = bus.wdata;
          if (bus.wr_lo) lo_d = bus.wdata;
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (last_iter) begin
          hi_d    = acc_d[2*WIDTH-1:WIDTH];
          lo_d    = acc_d[WIDTH-1:0];
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit against an arithmetic HI/LO reference.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  logic [63:0] exp_hl = '0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // Reference: plain arithmetic, returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op == 2'b01) begin
      p = 64'(a) * 64'(b);
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.dataA = a;
    bus.dataB = b;
    tick();
    bus.start = 1'b0;
    bus.op    = 2'b00;
  endtask

  // Called in a busy cycle; runs to the done cycle while scrambling operand inputs.
  task automatic wait_done(input string tag, input logic [63:0] exp, input logic [63:0] old_hl,
                           input int exp_cycles);
    int busy_cycles = 0;
    bit held = 1'b1;
    while (bus.busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      if ({bus.hi_out, bus.lo_out} !== old_hl) held = 1'b0;
      bus.dataA = $urandom;
      bus.dataB = $urandom;
      tick();
    end
    check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_cycles));
    check({tag, " hilo_held"}, 64'(held), 64'd1);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " hilo"}, {bus.hi_out, bus.lo_out}, exp);
    $display("op %s: hi=0x%08h lo=0x%08h cycles=%0d", tag, bus.hi_out, bus.lo_out, busy_cycles);
  endtask

  initial begin
    logic [31:0] a, b, d;
    logic [1:0]  op;
    logic [63:0] e;
    int          done_seen;

    bus.start = 1'b0; bus.op = 2'b00; bus.dataA = '0; bus.dataB = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;

    #1;
    check("reset hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // MULTU 3 x 5
    issue(2'b01, 32'd3, 32'd5);
    check("mul3x5 busy_after_accept", 64'(bus.busy), 64'd1);
    e = model(2'b01, 32'd3, 32'd5);
    check("mul3x5 model", e, 64'd15);
    wait_done("mul3x5", e, exp_hl, W);
    exp_hl = e;
    tick();
    check("mul3x5 done_single", 64'(bus.done), 64'd0);

    // Largest operands, operands scrambled while busy
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mulmax", 64'hFFFF_FFFE_0000_0001, exp_hl, W);
    exp_hl = 64'hFFFF_FFFE_0000_0001;
    tick();

    issue(2'b10, 32'd100, 32'd7);
    wait_done("div100_7", {32'd2, 32'd14}, exp_hl, W);
    exp_hl = {32'd2, 32'd14};
    tick();

    issue(2'b10, 32'h1234, 32'd0);
    wait_done("div_by_zero", {32'h1234, 32'hFFFF_FFFF}, exp_hl, W);
    exp_hl = {32'h1234, 32'hFFFF_FFFF};
    tick();

    // start DIVU + mthi at busy cycle 10 are both ignored
    a = $urandom; b = $urandom;
    issue(2'b01, a, b);
    repeat (9) tick();
    bus.start = 1'b1; bus.op = 2'b10; bus.wr_hi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0; bus.op = 2'b00; bus.wr_hi = 1'b0;
    e = model(2'b01, a, b);
    wait_done("mul_ignore_midstart", e, exp_hl, W - 10);
    exp_hl = e;
    // back-to-back start in the done cycle
    a = $urandom; b = $urandom;
    issue(2'b01, a, b);
    check("b2b accepted", 64'(bus.busy), 64'd1);
    e = model(2'b01, a, b);
    wait_done("mul_b2b", e, exp_hl, W);
    exp_hl = e;
    tick();

    // mthi / mtlo in idle
    bus.wr_hi = 1'b1; bus.wdata = 32'hAAAA_0000;
    tick();
    bus.wr_hi = 1'b0;
    exp_hl[63:32] = 32'hAAAA_0000;
    check("mthi", {bus.hi_out, bus.lo_out}, exp_hl);
    bus.wr_lo = 1'b1; bus.wdata = 32'h0000_5555;
    tick();
    bus.wr_lo = 1'b0;
    exp_hl[31:0] = 32'h0000_5555;
    check("mtlo", {bus.hi_out, bus.lo_out}, exp_hl);
    d = $urandom;
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = d;
    tick();
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    exp_hl = {d, d};
    check("mthi_mtlo_both", {bus.hi_out, bus.lo_out}, exp_hl);
    $display("mt writes: hi=0x%08h lo=0x%08h", bus.hi_out, bus.lo_out);

    // start + mtlo together: mtlo dropped
    bus.wr_lo = 1'b1; bus.wdata = 32'h1357_9BDF;
    issue(2'b01, 32'd7, 32'd9);
    bus.wr_lo = 1'b0;
    check("start_wins lo_unchanged", {bus.hi_out, bus.lo_out}, exp_hl);
    wait_done("mul7x9", {32'd0, 32'd63}, exp_hl, W);
    exp_hl = {32'd0, 32'd63};
    tick();

    // asynchronous reset mid-DIVU
    issue(2'b10, 32'hFFFF_0000, 32'd3);
    repeat (14) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    check("async_rst busy", 64'(bus.busy), 64'd0);
    check("async_rst done", 64'(bus.done), 64'd0);
    done_seen = 0;
    repeat (2) begin tick(); if (bus.done !== 1'b0) done_seen++; end
    rst = 1'b0;
    repeat (40) begin tick(); if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++; end
    check("async_rst no_done_after", 64'(done_seen), 64'd0);
    $display("reset abort: hi=0x%08h lo=0x%08h", bus.hi_out, bus.lo_out);
    exp_hl = '0;
    a = $urandom; b = $urandom_range(1, 1000);
    issue(2'b10, a, b);
    e = model(2'b10, a, b);
    wait_done("div_after_rst", e, exp_hl, W);
    exp_hl = e;
    tick();

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if (op == 2'b01 || op == 2'b10) begin
        issue(op, a, b);
        e = model(op, a, b);
        wait_done($sformatf("rand%0d_op%0d", i, op), e, exp_hl, W);
        exp_hl = e;
        tick();
        check($sformatf("rand%0d done_single", i), 64'(bus.done), 64'd0);
      end else begin
        issue(op, a, b);
        check($sformatf("rand%0d nop_busy", i), 64'(bus.busy), 64'd0);
        check($sformatf("rand%0d nop_hilo", i), {bus.hi_out, bus.lo_out}, exp_hl);
        $display("op rand%0d_op%0d: ignored", i, op);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
